pipe_skid_stage: RTL and testbench

- Generalised elastic pipeline register for the RISC-V pipeline; successor to the fixed-field inter-stage registers.
- Carries one opaque DataWidth-bit payload; stage wrappers pack and unpack their control and data fields into it.
- Two-entry skid buffer, so ready_o comes straight from a flop and full throughput is kept with no ready_i->ready_o combinational path.
- Adds a working pipeline flush, an occupancy output and a saturating stall counter.

---
 rtl/pipe_skid_stage.sv | 140 ++++++++++++++
 tb/tb_pipe_skid_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline register with a two-entry skid buffer.
// Holds one opaque payload per entry; the stage wrappers pack their fields into it.
// ready_o is decoded purely from the state flop, so there is no
// ready_i -> ready_o combinational path, and a single stall cycle is absorbed
// by the skid entry without losing throughput.
module pipe_skid_stage #(
    parameter int unsigned DataWidth        = 64,
    parameter bit          ClearDataOnReset = 1'b0,
    parameter int unsigned StallCntWidth    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     flush_i,
    input  logic                     clear_stats_i,
    input  logic [DataWidth-1:0]     data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [DataWidth-1:0]     data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [1:0]               count_o,
    output logic [StallCntWidth-1:0] stall_cnt_o
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e                   state_reg, state_next;
    logic [DataWidth-1:0]     main_reg, main_next;
    logic [DataWidth-1:0]     skid_reg, skid_next;
    logic [StallCntWidth-1:0] stall_cnt_reg, stall_cnt_next;

    logic acc;
    logic drn;
    logic stall;

    // Output decode: ready_o depends only on the state flop.
    assign ready_o     = (state_reg != ST_TWO);
    assign valid_o     = (state_reg != ST_EMPTY) & ~flush_i;
    assign data_o      = main_reg;
    assign count_o     = state_reg;
    assign stall_cnt_o = stall_cnt_reg;

    // A beat offered during flush is dropped even when ready_o reads 1,
    // because flush overrides every transition below.
    assign acc   = valid_i & ready_o;
    assign drn   = valid_o & ready_i;
    assign stall = (state_reg != ST_EMPTY) & ~flush_i & ~ready_i;

    // Next-state and payload steering; the main entry is always the oldest beat.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush_i) begin
            state_next = ST_EMPTY;
            if (ClearDataOnReset) begin
                main_next = '0;
                skid_next = '0;
            end
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (acc) begin
                        main_next  = data_i;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && drn) begin
                        main_next = data_i;
                    end else if (acc) begin
                        skid_next  = data_i;
                        state_next = ST_TWO;
                    end else if (drn) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // ready_o is low here, so no accept can coincide with the drain.
                    if (drn) begin
                        main_next  = skid_reg;
                        state_next = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating stall counter; clear wins over a simultaneous stall.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (clear_stats_i) begin
            stall_cnt_next = '0;
        end else if (stall && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + StallCntWidth'(1);
        end
    end

    // State and statistics registers; reset overrides flush, clear and handshakes.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_reg     <= ST_EMPTY;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Payload registers: optionally cleared on reset, otherwise reset-free.
    generate
        if (ClearDataOnReset) begin : g_data_clr
            // Payload storage with synchronous clear.
            always_ff @(posedge clk_i) begin
                if (!reset_ni) begin
                    main_reg <= '0;
                    skid_reg <= '0;
                end else begin
                    main_reg <= main_next;
                    skid_reg <= skid_next;
                end
            end
        end else begin : g_data_hold
            // Payload storage without reset; contents are only observed while valid_o=1.
            always_ff @(posedge clk_i) begin
                main_reg <= main_next;
                skid_reg <= skid_next;
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: table-driven directed vectors, hand-written
// saturation/reset sequences and a randomized run against a queue model.
module tb_pipe_skid_stage;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        flush_i;
    logic        clear_stats_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_i;

    logic        ready_o, valid_o;
    logic [7:0]  data_o;
    logic [1:0]  count_o;
    logic [3:0]  stall_cnt_o;

    logic        h_ready, h_valid;
    logic [7:0]  h_data;
    logic [1:0]  h_count;
    logic [15:0] h_stall;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: occupancy is the queue length, data_o is the queue head.
    logic [7:0]  q[$];
    logic [3:0]  m_stall   = '0;
    logic [15:0] m_stall16 = '0;

    always #5 clk_i = ~clk_i;

    pipe_skid_stage #(
        .DataWidth(8), .ClearDataOnReset(1'b1), .StallCntWidth(4)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i),
        .clear_stats_i(clear_stats_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .count_o(count_o), .stall_cnt_o(stall_cnt_o)
    );

    pipe_skid_stage #(
        .DataWidth(8), .ClearDataOnReset(1'b0), .StallCntWidth(16)
    ) u_hold (
        .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i),
        .clear_stats_i(clear_stats_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(h_ready), .data_o(h_data), .valid_o(h_valid),
        .ready_i(ready_i), .count_o(h_count), .stall_cnt_o(h_stall)
    );

    typedef struct {
        logic       flush;
        logic       clr;
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic       exp_valid;
        logic       exp_ready;
        logic [1:0] exp_count;
        logic [7:0] exp_data;
        logic [3:0] exp_stall;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic fl, logic clr, logic v, logic [7:0] d, logic r,
                                logic ev, logic er, logic [1:0] ec, logic [7:0] ed,
                                logic [3:0] es);
        vec_t t;
        t.flush = fl; t.clr = clr; t.valid = v; t.data = d; t.ready = r;
        t.exp_valid = ev; t.exp_ready = er; t.exp_count = ec;
        t.exp_data = ed; t.exp_stall = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst_n, input logic fl, input logic clr,
                         input logic v, input logic [7:0] d, input logic r);
        @(negedge clk_i);
        reset_ni      = rst_n;
        flush_i       = fl;
        clear_stats_i = clr;
        valid_i       = v;
        data_i        = d;
        ready_i       = r;
        #1;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic tick();
        int   sz;
        logic stl, acc, drn;
        @(posedge clk_i);
        sz = q.size();
        if (!reset_ni) begin
            q.delete();
            m_stall   = '0;
            m_stall16 = '0;
        end else begin
            stl = (sz > 0) && !flush_i && !ready_i;
            if (clear_stats_i) begin
                m_stall   = '0;
                m_stall16 = '0;
            end else if (stl) begin
                if (m_stall != 4'hF) m_stall = m_stall + 4'd1;
                if (m_stall16 != 16'hFFFF) m_stall16 = m_stall16 + 16'd1;
            end
            if (flush_i) begin
                q.delete();
            end else begin
                drn = (sz > 0) && ready_i;
                acc = valid_i && (sz < 2);
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(data_i);
            end
        end
    endtask

    task automatic model_check();
        logic ev, er;
        ev = (q.size() > 0) && !flush_i;
        er = (q.size() < 2);
        chk("valid", valid_o, ev);
        chk("ready", ready_o, er);
        chk("count", count_o, q.size());
        chk("stall", stall_cnt_o, m_stall);
        if (ev) chk("data", data_o, q[0]);
        chk("h_valid", h_valid, ev);
        chk("h_ready", h_ready, er);
        chk("h_count", h_count, q.size());
        chk("h_stall", h_stall, m_stall16);
        if (ev) chk("h_data", h_data, q[0]);
    endtask

    initial begin
        // Directed vectors: expected outputs seen during the cycle, before its edge.
        tbl[0]  = mk(0,0,1,8'h01,1, 0,1,0,8'h00,0);
        tbl[1]  = mk(0,0,1,8'h02,1, 1,1,1,8'h01,0);
        tbl[2]  = mk(0,0,1,8'h03,1, 1,1,1,8'h02,0);
        tbl[3]  = mk(0,0,0,8'h00,1, 1,1,1,8'h03,0);
        tbl[4]  = mk(0,0,0,8'h00,1, 0,1,0,8'h03,0);
        tbl[5]  = mk(0,0,1,8'h0A,0, 0,1,0,8'h03,0);
        tbl[6]  = mk(0,0,1,8'h0B,0, 1,1,1,8'h0A,0);
        tbl[7]  = mk(0,0,1,8'h0C,0, 1,0,2,8'h0A,1);
        tbl[8]  = mk(0,0,1,8'h0C,0, 1,0,2,8'h0A,2);
        tbl[9]  = mk(0,0,1,8'h0C,1, 1,0,2,8'h0A,3);
        tbl[10] = mk(0,0,1,8'h0C,1, 1,1,1,8'h0B,3);
        tbl[11] = mk(0,0,0,8'h00,1, 1,1,1,8'h0C,3);
        tbl[12] = mk(0,0,0,8'h00,1, 0,1,0,8'h0C,3);
        tbl[13] = mk(0,1,0,8'h00,0, 0,1,0,8'h0C,3);
        tbl[14] = mk(0,0,1,8'h11,0, 0,1,0,8'h0C,0);
        tbl[15] = mk(0,0,1,8'h22,0, 1,1,1,8'h11,0);
        tbl[16] = mk(1,0,1,8'h33,0, 0,0,2,8'h11,1);
        tbl[17] = mk(0,0,0,8'h00,1, 0,1,0,8'h00,1);
        tbl[18] = mk(0,0,1,8'h44,1, 0,1,0,8'h00,1);
        tbl[19] = mk(0,0,0,8'h00,1, 1,1,1,8'h44,1);
        tbl[20] = mk(0,0,0,8'h00,1, 0,1,0,8'h44,1);

        reset_ni = 1'b0; flush_i = 1'b0; clear_stats_i = 1'b0;
        data_i = '0; valid_i = 1'b0; ready_i = 1'b0;

        // Reset, then check the idle state.
        drive(0,0,0,0,8'h00,0); tick();
        drive(0,0,0,0,8'h00,0); tick();
        drive(1,0,0,0,8'h00,0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_count", count_o, 2'd0);
        chk("rst_stall", stall_cnt_o, 4'd0);
        chk("rst_data",  data_o, 8'h00);
        tick();

        // Table: streaming, skid fill, stats clear, flush with data clear.
        for (int i = 0; i < 21; i++) begin
            drive(1, tbl[i].flush, tbl[i].clr, tbl[i].valid, tbl[i].data, tbl[i].ready);
            $display("vec %0d: valid_i=%0b data_i=%0h ready_i=%0b flush=%0b -> valid_o=%0b ready_o=%0b count=%0d data_o=%0h stall=%0d",
                     i, tbl[i].valid, tbl[i].data, tbl[i].ready, tbl[i].flush,
                     valid_o, ready_o, count_o, data_o, stall_cnt_o);
            chk("tbl_valid", valid_o, tbl[i].exp_valid);
            chk("tbl_ready", ready_o, tbl[i].exp_ready);
            chk("tbl_count", count_o, tbl[i].exp_count);
            chk("tbl_data",  data_o,  tbl[i].exp_data);
            chk("tbl_stall", stall_cnt_o, tbl[i].exp_stall);
            if (i == 17) chk("hold_data_after_flush", h_data, 8'h11);
            tick();
        end

        // Saturation: stall for 20 cycles with one entry held.
        drive(1,0,1,0,8'h00,0); tick();
        drive(1,0,0,1,8'h55,0); tick();
        for (int i = 0; i < 20; i++) begin
            drive(1,0,0,0,8'h00,0);
            model_check();
            tick();
        end
        drive(1,0,0,0,8'h00,0);
        chk("sat_stall", stall_cnt_o, 4'hF);
        $display("saturation: stall_cnt_o=%0d", stall_cnt_o);
        tick();
        drive(1,0,1,0,8'h00,0);
        chk("sat_hold", stall_cnt_o, 4'hF);
        tick();
        drive(1,0,0,0,8'h00,0);
        chk("clr_during_stall", stall_cnt_o, 4'd0);
        $display("clear: stall_cnt_o=%0d", stall_cnt_o);
        tick();

        // Reset mid-operation in TWO with stall_cnt=5, plus flush and a beat.
        drive(1,0,0,1,8'h66,0);
        chk("pre_stall1", stall_cnt_o, 4'd1);
        chk("pre_count1", count_o, 2'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1,0,0,0,8'h00,0);
            tick();
        end
        drive(0,1,0,1,8'h77,0);
        chk("pre_rst_count", count_o, 2'd2);
        chk("pre_rst_stall", stall_cnt_o, 4'd5);
        tick();
        drive(1,0,0,0,8'h00,1);
        chk("mid_rst_count", count_o, 2'd0);
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_ready", ready_o, 1'b1);
        chk("mid_rst_stall", stall_cnt_o, 4'd0);
        $display("mid-reset: count=%0d valid=%0b ready=%0b stall=%0d",
                 count_o, valid_o, ready_o, stall_cnt_o);
        model_check();
        tick();

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            logic fl, clr, v, r;
            logic [7:0] d;
            fl  = ($urandom_range(0, 99) < 5);
            clr = ($urandom_range(0, 99) < 1);
            v   = $urandom_range(0, 1);
            r   = $urandom_range(0, 1);
            d   = 8'($urandom);
            drive(1, fl, clr, v, d, r);
            model_check();
            // ready_o must not respond to ready_i within the cycle.
            ready_i = ~r;
            #1;
            chk("ready_vs_ready_i", ready_o, (q.size() < 2));
            ready_i = r;
            #1;
            tick();
        end
        $display("random: 10000 cycles done, model queue depth %0d", q.size());

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
